// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/grant/done handshake between the MEM-stage load/store
// unit and the memory controller.
//
// Handshake: the LSU raises mc_req_o with mc_we_o/mc_addr_o/mc_wdata_o/
// mc_len_o and keeps all of them stable until it samples mc_gnt_i high on a
// rising clock edge. mc_gnt_i is meaningful only while mc_req_o is high.
// mc_done_i marks the end of the granted beat; it may come in the same cycle
// as mc_gnt_i or any later cycle. mc_rdata_i is valid only while mc_done_i
// is high.
//
// Ports (master = LSU side):
//   mc_req_o    beat request
//   mc_we_o     1 = write beat
//   mc_addr_o   beat byte address
//   mc_wdata_o  beat write data (8*BEAT_BYTES)
//   mc_len_o    bytes in the beat
//   mc_gnt_i    controller accepted the request
//   mc_done_i   beat complete
//   mc_rdata_i  beat read data (8*BEAT_BYTES)
interface mem_lsu_if #(
  parameter int BEAT_BYTES = 1
);
  logic                    mc_req_o;
  logic                    mc_we_o;
  logic [31:0]             mc_addr_o;
  logic [8*BEAT_BYTES-1:0] mc_wdata_o;
  logic [2:0]              mc_len_o;
  logic                    mc_gnt_i;
  logic                    mc_done_i;
  logic [8*BEAT_BYTES-1:0] mc_rdata_i;

  modport master (
    output mc_req_o, mc_we_o, mc_addr_o, mc_wdata_o, mc_len_o,
    input  mc_gnt_i, mc_done_i, mc_rdata_i
  );

  modport slave (
    input  mc_req_o, mc_we_o, mc_addr_o, mc_wdata_o, mc_len_o,
    output mc_gnt_i, mc_done_i, mc_rdata_i
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit. Splits each load/store into memory
// controller beats of BEAT_BYTES bytes, assembles little-endian read data,
// sign/zero extends loads, stalls the pipeline until the access completes
// and drives the MEM->ID forward path. Non-memory instructions pass straight
// through combinationally.
//
// Ports:
//   clk_in, rst_in            clock, asynchronous active-low reset
//   input_rd_addr/_rd_data    destination register / ALU result from ex_mem
//   write_or_not              ex_mem writeback enable
//   mem_op                    00 none, 01 load, 10 store, 11 none
//   mem_size                  0 byte, 1 half, 2/3 word
//   mem_unsigned              zero-extend loads
//   mem_addr, store_data      effective address, store source
//   out_rd_addr/_rd_data/out_write_or_not   to mem_wb
//   mem_forward_*_o           forward path to id
//   stall_from_mem            to stallctrl
//   mc                        memory controller handshake (master side)
//   dbg_state_o               current FSM state (0 IDLE,1 ISSUE,2 WAIT,3 FINISH)
module mem_lsu #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int BEAT_BYTES = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [REG_ADDR_W-1:0] input_rd_addr,
  input  logic [XLEN-1:0]       input_rd_data,
  input  logic                  write_or_not,
  input  logic [1:0]            mem_op,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [31:0]           mem_addr,
  input  logic [XLEN-1:0]       store_data,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic [XLEN-1:0]       out_rd_data,
  output logic                  out_write_or_not,
  output logic                  mem_forward_id_o,
  output logic [REG_ADDR_W-1:0] mem_forward_addr_o,
  output logic [XLEN-1:0]       mem_forward_data_o,
  output logic                  stall_from_mem,
  mem_lsu_if.master             mc,
  output logic [1:0]            dbg_state_o
);

  localparam int BW     = 8 * BEAT_BYTES;
  localparam int NBYTES = XLEN / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  function automatic logic [2:0] f_bytes(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] f_len(input logic [2:0] bytes);
    return (int'(bytes) < BEAT_BYTES) ? bytes : 3'(BEAT_BYTES);
  endfunction

  // Index of the last beat (nbeats - 1).
  function automatic logic [1:0] f_last(input logic [2:0] bytes);
    return (int'(bytes) <= BEAT_BYTES) ? 2'd0 : 2'(int'(bytes) / BEAT_BYTES - 1);
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            load_q, load_d;
  logic [XLEN-1:0] sd_q, sd_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [BW-1:0]   wdata_q, wdata_d;
  logic [2:0]      len_q, len_d;

  logic            is_mem;
  logic            beat_done;
  logic            last_beat;
  logic [XLEN-1:0] ext_data;

  assign is_mem    = (mem_op == 2'b01) || (mem_op == 2'b10);
  assign last_beat = (cnt_q == last_q);
  // A beat finishes on grant+done in ISSUE, or on done in WAIT; a done in
  // any other state is stray and ignored.
  assign beat_done = ((state_q == S_ISSUE) && mc.mc_gnt_i && mc.mc_done_i) ||
                     ((state_q == S_WAIT) && mc.mc_done_i);

  // ---------------- state register ----------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      last_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      load_q  <= 1'b0;
      sd_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      load_q  <= load_d;
      sd_q    <= sd_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (is_mem) state_d = S_ISSUE;
      S_ISSUE: begin
        if (mc.mc_gnt_i) begin
          if (!mc.mc_done_i)  state_d = S_WAIT;
          else if (last_beat) state_d = S_FINISH;
        end
      end
      S_WAIT:   if (mc.mc_done_i) state_d = last_beat ? S_FINISH : S_ISSUE;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- beat datapath ----------------
  always_comb begin
    int idx;
    idx     = 0;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    last_d  = last_q;
    size_d  = size_q;
    uns_d   = uns_q;
    load_d  = load_q;
    sd_d    = sd_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    len_d   = len_q;

    if (state_q == S_IDLE && is_mem) begin
      // Capture the access shape once; ex_mem is not re-sampled afterwards.
      cnt_d   = '0;
      buf_d   = '0;
      last_d  = f_last(f_bytes(mem_size));
      size_d  = mem_size;
      uns_d   = mem_unsigned;
      load_d  = (mem_op == 2'b01);
      sd_d    = store_data;
      we_d    = (mem_op == 2'b10);
      addr_d  = mem_addr;
      wdata_d = BW'(store_data);
      len_d   = f_len(f_bytes(mem_size));
    end else if (beat_done) begin
      if (load_q) begin
        for (int b = 0; b < BEAT_BYTES; b++) begin
          idx = int'(cnt_q) * BEAT_BYTES + b;
          if (b < int'(len_q) && idx < NBYTES)
            buf_d[idx*8 +: 8] = mc.mc_rdata_i[b*8 +: 8];
        end
      end
      if (!last_beat) begin
        cnt_d   = cnt_q + 2'd1;
        addr_d  = addr_q + 32'(BEAT_BYTES);
        wdata_d = BW'(sd_q >> (BW * (int'(cnt_q) + 1)));
      end
    end
  end

  // Extend the assembled buffer from bit 8*bytes-1: shift the live bytes to
  // the top, then shift back logically or arithmetically.
  always_comb begin
    int          sh;
    logic [XLEN-1:0] tmp;
    sh  = XLEN - 8 * int'(f_bytes(size_q));
    tmp = buf_q << sh;
    if (uns_q) ext_data = tmp >> sh;
    else       ext_data = XLEN'($signed(tmp) >>> sh);
  end

  // ---------------- outputs ----------------
  always_comb begin
    out_rd_addr      = input_rd_addr;
    out_rd_data      = input_rd_data;
    out_write_or_not = 1'b0;
    stall_from_mem   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem) stall_from_mem   = 1'b1;
        else        out_write_or_not = write_or_not;
      end
      S_ISSUE, S_WAIT: stall_from_mem = 1'b1;
      S_FINISH: begin
        if (load_q) begin
          out_rd_data      = ext_data;
          out_write_or_not = 1'b1;
        end else begin
          out_write_or_not = write_or_not;
        end
      end
      default: ;
    endcase
    if (!rst_in) begin
      out_rd_addr      = '0;
      out_rd_data      = '0;
      out_write_or_not = 1'b0;
      stall_from_mem   = 1'b0;
    end
    mem_forward_id_o   = out_write_or_not;
    mem_forward_addr_o = out_write_or_not ? out_rd_addr : '0;
    mem_forward_data_o = out_write_or_not ? out_rd_data : '0;
  end

  assign mc.mc_req_o   = rst_in && (state_q == S_ISSUE);
  assign mc.mc_we_o    = we_q;
  assign mc.mc_addr_o  = addr_q;
  assign mc.mc_wdata_o = wdata_q;
  assign mc.mc_len_o   = len_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: drives three mem_lsu instances (BEAT_BYTES 1, 2, 4) that share
// the ex_mem inputs; only the selected instance sees a memory op. Each has
// its own memory-controller responder with programmable grant/done delays
// and optional stray handshake pulses, backed by a byte memory.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_rd_data;
  logic        in_we;
  logic [1:0]  in_op;
  logic [1:0]  in_size;
  logic        in_uns;
  logic [31:0] in_addr;
  logic [31:0] in_sdata;
  int          sel;

  wire [4:0]  o_rd_addr [3];
  wire [31:0] o_rd_data [3];
  wire        o_we      [3];
  wire        o_fv      [3];
  wire [4:0]  o_fa      [3];
  wire [31:0] o_fd      [3];
  wire        o_stall   [3];
  wire        o_req     [3];
  wire [1:0]  o_dbg     [3];

  int         gnt_dly  [3];
  int         done_dly [3];
  bit         spur     [3];
  logic [7:0] mem      [3][1024];
  logic [67:0] beat_log [3][$];   // {we, len, addr, wdata}
  logic [67:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int BB = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    mem_lsu_if #(.BEAT_BYTES(BB)) mc_if ();
    wire [1:0] op_l = (sel == g) ? in_op : 2'b00;
    int ph = 0;
    int cnt = 0;

    mem_lsu #(.XLEN(32), .REG_ADDR_W(5), .BEAT_BYTES(BB)) u_dut (
      .clk_in(clk), .rst_in(rst_n),
      .input_rd_addr(in_rd_addr), .input_rd_data(in_rd_data),
      .write_or_not(in_we), .mem_op(op_l), .mem_size(in_size),
      .mem_unsigned(in_uns), .mem_addr(in_addr), .store_data(in_sdata),
      .out_rd_addr(o_rd_addr[g]), .out_rd_data(o_rd_data[g]),
      .out_write_or_not(o_we[g]), .mem_forward_id_o(o_fv[g]),
      .mem_forward_addr_o(o_fa[g]), .mem_forward_data_o(o_fd[g]),
      .stall_from_mem(o_stall[g]), .mc(mc_if), .dbg_state_o(o_dbg[g])
    );
    assign o_req[g] = mc_if.mc_req_o;

    // Responder: grant after gnt_dly waiting cycles, done done_dly cycles
    // after the grant (0 = same cycle).
    always @(negedge clk) begin
      mc_if.mc_gnt_i   = 1'b0;
      mc_if.mc_done_i  = 1'b0;
      mc_if.mc_rdata_i = '0;
      if (!rst_n) begin
        ph = 0; cnt = 0;
      end else if (ph == 0 && mc_if.mc_req_o) begin
        if (cnt >= gnt_dly[g]) begin
          mc_if.mc_gnt_i = 1'b1;
          cnt = 0;
          beat_log[g].push_back({mc_if.mc_we_o, mc_if.mc_len_o, mc_if.mc_addr_o,
                                 32'(mc_if.mc_wdata_o)});
          if (mc_if.mc_we_o)
            for (int b = 0; b < BB; b++)
              if (b < int'(mc_if.mc_len_o))
                mem[g][10'(mc_if.mc_addr_o + 32'(b))] = mc_if.mc_wdata_o[b*8 +: 8];
          if (done_dly[g] == 0) begin
            mc_if.mc_done_i = 1'b1;
            for (int b = 0; b < BB; b++)
              mc_if.mc_rdata_i[b*8 +: 8] = mem[g][10'(mc_if.mc_addr_o + 32'(b))];
          end else begin
            ph = 1;
          end
        end else begin
          cnt++;
          if (spur[g]) mc_if.mc_done_i = 1'($urandom_range(0, 1));
        end
      end else if (ph == 1) begin
        cnt++;
        if (cnt >= done_dly[g]) begin
          mc_if.mc_done_i = 1'b1;
          for (int b = 0; b < BB; b++)
            mc_if.mc_rdata_i[b*8 +: 8] = mem[g][10'(mc_if.mc_addr_o + 32'(b))];
          ph = 0; cnt = 0;
        end
      end else if (spur[g]) begin
        mc_if.mc_gnt_i   = 1'($urandom_range(0, 1));
        mc_if.mc_done_i  = 1'($urandom_range(0, 1));
        mc_if.mc_rdata_i = (8*BB)'($urandom);
      end
    end
  end

  function automatic int bb_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 4;
  endfunction

  // Reference load: little-endian bytes from memory, extended by arithmetic.
  function automatic logic [31:0] model_load(input int g, input logic [31:0] a,
                                             input int bytes, input logic uns);
    longint v;
    v = 0;
    for (int i = 0; i < bytes; i++)
      v = v | (longint'(mem[g][10'(a + 32'(i))]) << (8 * i));
    if (!uns && v[8*bytes-1]) v = v - (longint'(1) << (8 * bytes));
    return v[31:0];
  endfunction

  task automatic set_nop();
    in_op = 2'b00; in_size = 2'd0; in_uns = 1'b0; in_addr = '0; in_sdata = '0;
  endtask

  // Issue one memory op on instance g; returns at #1 after the edge that
  // ends FINISH, with a nop on the inputs.
  task automatic do_op(input int g, input logic [1:0] op, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] rd,
                       input logic we, input logic [31:0] alu, input string tag);
    int bb, bytes, nb, ln, stalls, reqs, exp_stall, exp_req;
    logic [31:0] exp_load, mask, exp_fd;
    logic [67:0] e, a;
    logic exp_we;
    bb    = bb_of(g);
    bytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    nb    = (bytes > bb) ? bytes / bb : 1;
    ln    = (bytes < bb) ? bytes : bb;
    mask  = 32'((64'd1 << (8 * ln)) - 64'd1);
    exp_stall = 1 + nb * (gnt_dly[g] + 1 + done_dly[g]);
    exp_req   = nb * (gnt_dly[g] + 1);
    exp_load  = model_load(g, addr, bytes, uns);
    exp_we    = (op == 2'b01) ? 1'b1 : we;
    exp_fd    = (op == 2'b01) ? exp_load : alu;
    exp_q.delete();
    for (int k = 0; k < nb; k++)
      exp_q.push_back({op == 2'b10, 3'(ln), addr + 32'(k * bb),
                       (op == 2'b10) ? ((sdata >> (8 * bb * k)) & mask) : 32'd0});
    sel = g; in_op = op; in_size = size; in_uns = uns; in_addr = addr;
    in_sdata = sdata; in_rd_addr = rd; in_we = we; in_rd_data = alu;
    stalls = 0; reqs = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (!o_stall[g]) break;
      stalls++;
      if (o_req[g]) reqs++;
      if (stalls > 1) begin
        n_checks++;
        if (o_we[g] !== 1'b0) begin
          n_errors++;
          $display("FAIL %s we_during_stall: got %0b want 0", tag, o_we[g]);
        end
      end
      @(posedge clk); #1;
    end
    // FINISH cycle
    n_checks++;
    if (stalls != exp_stall) begin
      n_errors++;
      $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, exp_stall);
    end
    n_checks++;
    if (reqs != exp_req) begin
      n_errors++;
      $display("FAIL %s req_cycles: got %0d want %0d", tag, reqs, exp_req);
    end
    n_checks++;
    if (o_we[g] !== exp_we) begin
      n_errors++;
      $display("FAIL %s finish_we: got %0b want %0b", tag, o_we[g], exp_we);
    end
    n_checks++;
    if (o_rd_addr[g] !== rd) begin
      n_errors++;
      $display("FAIL %s finish_rd: got %0d want %0d", tag, o_rd_addr[g], rd);
    end
    n_checks++;
    if (o_fv[g] !== exp_we) begin
      n_errors++;
      $display("FAIL %s fwd_valid: got %0b want %0b", tag, o_fv[g], exp_we);
    end
    if (op == 2'b01) begin
      n_checks++;
      if (o_rd_data[g] !== exp_load) begin
        n_errors++;
        $display("FAIL %s load_data: got %h want %h", tag, o_rd_data[g], exp_load);
      end
      n_checks++;
      if (o_fd[g] !== exp_fd || o_fa[g] !== rd) begin
        n_errors++;
        $display("FAIL %s fwd_data: got %0d/%h want %0d/%h", tag, o_fa[g], o_fd[g], rd, exp_fd);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (beat_log[g].size() == 0) begin
        n_errors++;
        $display("FAIL %s beat_missing: got none want %h", tag, e);
      end else begin
        a = beat_log[g].pop_front();
        if (a[67] === 1'b1) a[31:0] = a[31:0] & mask;
        else                a[31:0] = '0;
        if (a !== e) begin
          n_errors++;
          $display("FAIL %s beat: got %h want %h", tag, a, e);
        end
      end
    end
    n_checks++;
    if (beat_log[g].size() != 0) begin
      n_errors++;
      $display("FAIL %s extra_beats: got %0d want 0", tag, beat_log[g].size());
      beat_log[g].delete();
    end
    if (op == 2'b10)
      for (int i = 0; i < bytes; i++) begin
        n_checks++;
        if (mem[g][10'(addr + 32'(i))] !== sdata[8*i +: 8]) begin
          n_errors++;
          $display("FAIL %s store_byte%0d: got %h want %h", tag, i,
                   mem[g][10'(addr + 32'(i))], sdata[8*i +: 8]);
        end
      end
    @(posedge clk); #1;
    set_nop();
  endtask

  // Non-memory instruction: same-cycle pass-through on instance g.
  task automatic do_alu(input int g, input logic [1:0] op, input logic [4:0] rd,
                        input logic [31:0] d, input logic we, input string tag);
    sel = g; in_op = op; in_rd_addr = rd; in_rd_data = d; in_we = we;
    @(negedge clk); #1;
    n_checks++;
    if (o_rd_addr[g] !== rd || o_rd_data[g] !== d || o_we[g] !== we || o_stall[g] !== 1'b0) begin
      n_errors++;
      $display("FAIL %s passthru: got %0d/%h/%0b/%0b want %0d/%h/%0b/0", tag,
               o_rd_addr[g], o_rd_data[g], o_we[g], o_stall[g], rd, d, we);
    end
    n_checks++;
    if (o_fv[g] !== we || o_fa[g] !== (we ? rd : 5'd0) || o_fd[g] !== (we ? d : 32'd0)) begin
      n_errors++;
      $display("FAIL %s fwd: got %0b/%0d/%h want %0b/%0d/%h", tag, o_fv[g], o_fa[g],
               o_fd[g], we, we ? rd : 5'd0, we ? d : 32'd0);
    end
    @(posedge clk); #1;
    set_nop();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel = 0; in_op = 2'b01; in_size = 2'd2; in_uns = 1'b0; in_addr = 32'h100;
    in_sdata = 32'h5555_AAAA; in_rd_addr = 5'd9; in_rd_data = 32'hDEAD_BEEF; in_we = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (o_stall[g] !== 1'b0 || o_req[g] !== 1'b0 || o_we[g] !== 1'b0 ||
          o_rd_data[g] !== 32'd0 || o_fv[g] !== 1'b0 || o_dbg[g] !== 2'd0) begin
        n_errors++;
        $display("FAIL reset_outputs%0d: got stall=%0b req=%0b we=%0b data=%h fv=%0b st=%0d want all 0",
                 g, o_stall[g], o_req[g], o_we[g], o_rd_data[g], o_fv[g], o_dbg[g]);
      end
    end
    n_checks++;
    if (gd[0].mc_if.mc_addr_o !== 32'd0 || gd[0].mc_if.mc_len_o !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_mc_regs: got %h/%0d want 0/0", gd[0].mc_if.mc_addr_o,
               gd[0].mc_if.mc_len_o);
    end
    set_nop();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    do_alu(0, 2'b00, 5'd5, 32'h0000_1234, 1'b1, "alu_example");
    for (int i = 0; i < 6; i++)
      do_alu($urandom_range(0, 2), ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00,
             5'($urandom), $urandom, 1'($urandom_range(0, 1)), "alu_rand");
  endtask

  task automatic test_byte_load();
    gnt_dly[0] = 0; done_dly[0] = 0;
    mem[0][10'h100] = 8'h80;
    do_op(0, 2'b01, 2'd0, 1'b0, 32'h100, 32'd0, 5'd3, 1'b0, 32'd0, "lb_signed");
    do_op(0, 2'b01, 2'd0, 1'b1, 32'h100, 32'd0, 5'd3, 1'b0, 32'd0, "lbu");
  endtask

  task automatic test_split_word();
    mem[0][10'h200] = 8'h78; mem[0][10'h201] = 8'h56;
    mem[0][10'h202] = 8'h34; mem[0][10'h203] = 8'h12;
    do_op(0, 2'b01, 2'd2, 1'b0, 32'h200, 32'd0, 5'd4, 1'b0, 32'd0, "lw_split");
    gnt_dly[2] = 0; done_dly[2] = 0;
    do_op(2, 2'b01, 2'd2, 1'b0, 32'h200, 32'd0, 5'd4, 1'b0, 32'd0, "lw_bb4");
  endtask

  task automatic test_half_store();
    gnt_dly[1] = 3; done_dly[1] = 1;
    do_op(1, 2'b10, 2'd1, 1'b0, 32'h10, 32'h0000_ABCD, 5'd0, 1'b0, 32'd0, "sh_bb2");
    gnt_dly[1] = 0; done_dly[1] = 0;
  endtask

  task automatic test_load_use();
    mem[0][10'h300] = 8'hEF; mem[0][10'h301] = 8'hBE;
    mem[0][10'h302] = 8'hAD; mem[0][10'h303] = 8'hDE;
    do_op(0, 2'b01, 2'd2, 1'b0, 32'h300, 32'd0, 5'd7, 1'b0, 32'd0, "lw_use");
    do_alu(0, 2'b00, 5'd8, 32'hDEAD_BEF0, 1'b1, "add_after_lw");
  endtask

  task automatic test_reset_mid();
    bit hit;
    gnt_dly[0] = 0; done_dly[0] = 3;
    sel = 0; in_op = 2'b01; in_size = 2'd2; in_uns = 1'b0; in_addr = 32'h40;
    in_rd_addr = 5'd2; in_we = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk); #1;
      if (beat_log[0].size() == 2 && o_req[0] === 1'b0) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_errors++;
      $display("FAIL rst_mid_reach: got beats=%0d want 2", beat_log[0].size());
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_req[0] !== 1'b0 || o_stall[0] !== 1'b0 || o_we[0] !== 1'b0 ||
        o_rd_data[0] !== 32'd0 || o_dbg[0] !== 2'd0) begin
      n_errors++;
      $display("FAIL rst_mid_outputs: got req=%0b stall=%0b we=%0b data=%h st=%0d want 0",
               o_req[0], o_stall[0], o_we[0], o_rd_data[0], o_dbg[0]);
    end
    set_nop();
    beat_log[0].delete();
    done_dly[0] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(0, 2'b10, 2'd0, 1'b0, 32'h50, 32'h0000_00A5, 5'd0, 1'b0, 32'd0, "sb_after_rst");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      int g;
      g = $urandom_range(0, 2);
      gnt_dly[g]  = $urandom_range(0, 2);
      done_dly[g] = $urandom_range(0, 2);
      spur[g]     = ($urandom_range(0, 1) != 0);
      do_op(g, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 32'($urandom_range(0, 1000)), $urandom,
            5'($urandom), 1'($urandom_range(0, 1)), $urandom, "rand");
      spur[g] = 1'b0;
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      gnt_dly[g] = 0; done_dly[g] = 0; spur[g] = 1'b0;
      for (int i = 0; i < 1024; i++) mem[g][i] = 8'($urandom);
    end
    #1;
    test_reset();
    test_passthrough();
    test_byte_load();
    test_split_word();
    test_half_store();
    test_load_use();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised MEM-stage load/store unit. It replaces the purely combinational MEM stage with a sequencing FSM that splits each access into memory-controller beats of `BEAT_BYTES` bytes. It assembles little-endian read data, applies sign or zero extension, stalls the pipeline until the access completes, and drives the MEM→ID forward path. It sits between ex_mem and mem_wb and talks to mem ctrl through a request/grant/done handshake.

## Interface
- `XLEN`, default 32: register and data width.
- `REG_ADDR_W`, default 5: register address width.
- `BEAT_BYTES`, default 1: bytes per mem ctrl beat. Legal values are 1, 2 and 4.
- `clk_in` input, 1: the single clock.
- `rst_in` input, 1: asynchronous, active-low reset.
- `input_rd_addr` input, REG_ADDR_W: destination register from ex_mem.
- `input_rd_data` input, XLEN: ALU result from ex_mem.
- `write_or_not` input, 1: ex_mem writeback enable.
- `mem_op` input, 2: 00 none, 01 load, 10 store, 11 treated as none.
- `mem_size` input, 2: 0 byte, 1 half, 2 word, 3 treated as word.
- `mem_unsigned` input, 1: zero-extend loads when high.
- `mem_addr` input, 32: effective byte address.
- `store_data` input, XLEN: store source data.
- `out_rd_addr` output, REG_ADDR_W: to mem_wb.
- `out_rd_data` output, XLEN: to mem_wb.
- `out_write_or_not` output, 1: to mem_wb.
- `mem_forward_id_o` output, 1: forward valid to id.
- `mem_forward_addr_o` output, REG_ADDR_W: forward register address.
- `mem_forward_data_o` output, XLEN: forward data.
- `stall_from_mem` output, 1: to stallctrl.
- `mc_req_o` output, 1: beat request.
- `mc_we_o` output, 1: 1 = write beat.
- `mc_addr_o` output, 32: beat byte address.
- `mc_wdata_o` output, 8*BEAT_BYTES: beat write data.
- `mc_len_o` output, 3: bytes in the beat.
- `mc_gnt_i` input, 1: mem ctrl accepted the request.
- `mc_done_i` input, 1: beat complete.
- `mc_rdata_i` input, 8*BEAT_BYTES: beat read data, valid when `mc_done_i` is high.

## Operation
- Access size: `bytes = 1 << mem_size`, with size 3 treated as 4.
- Beat count: `nbeats = max(1, bytes / BEAT_BYTES)`.
- Beat length: `len = min(bytes, BEAT_BYTES)`.
- Beat k address: `mem_addr + k*BEAT_BYTES`. Addresses are not checked for alignment.
- Beat k write data: `store_data[8*BEAT_BYTES*k +: 8*BEAT_BYTES]`. Bytes above `len` are don't-care.
- FSM states are IDLE, ISSUE, WAIT and FINISH. A 2-bit beat counter and an XLEN assembly buffer are added.
- **IDLE, no memory op:** pass-through. `out_*` equal the ex_mem inputs and `stall_from_mem = 0`.
- **IDLE, load or store:**
  - `stall_from_mem = 1` combinationally.
  - Register beat 0 onto the `mc_*` outputs, clear the buffer and counter, then go to ISSUE.
- **ISSUE:**
  - `mc_req_o = 1`. All `mc_*` outputs are held stable until `mc_gnt_i` is seen.
  - On grant without done, drop `mc_req_o` and go to WAIT.
  - On grant with done in the same cycle, complete the beat immediately.
- **WAIT:** `mc_req_o = 0`. On `mc_done_i`, complete the beat.
- **Beat completion:**
  - For loads, write `mc_rdata_i[8*len-1:0]` into buffer bytes `[k*BEAT_BYTES +: len]`.
  - If `k == nbeats-1`, go to FINISH. Otherwise increment k, register beat k+1 and go to ISSUE.
- **FINISH** lasts exactly one cycle, with `stall_from_mem = 0`:
  - Loads: `out_rd_data` is the buffer extended from bit `8*bytes-1`, signed unless `mem_unsigned`, and `out_write_or_not = 1`.
  - Stores: `out_write_or_not = write_or_not`.
  - Return to IDLE. ex_mem advances on this edge, so the following IDLE sees the next instruction.
- **Forward path:** whenever `out_write_or_not = 1`, `mem_forward_id_o = 1` and the forward address and data equal `out_rd_addr` and `out_rd_data`. Otherwise all three are 0.
- **During ISSUE and WAIT:** `stall_from_mem = 1` and `out_write_or_not = 0`.
- **Input stability:** ex_mem inputs are held stable while stalled. `mem_lsu` still latches `nbeats`, size, unsigned and op at IDLE and does not re-sample them later.

## Timing
- **Reset (`rst_in` low), async:**
  - State goes to IDLE; counter, buffer and all registered `mc_*` outputs go to 0.
  - All combinational outputs read 0 while `rst_in` is low.
  - A reset mid-access drops `mc_req_o` immediately. mem ctrl is reset by the same signal.
- **Latency with grant and done in the same cycle as the request:** stall is high for `1 + nbeats` cycles, and the result appears in the next (FINISH) cycle.
  - Example: a word load with `BEAT_BYTES = 4` gives stall for 2 cycles and the result in cycle 3.
  - Example: a word load with `BEAT_BYTES = 1` gives stall for 5 cycles.
- **Extra latency:** each cycle without grant or done adds one stall cycle.
- **Spurious inputs:** `mc_done_i` in IDLE or ISSUE-without-grant is ignored. `mc_gnt_i` while `mc_req_o = 0` is ignored.
- **Back-to-back memory ops:** FINISH → IDLE → ISSUE. There is no bubble beyond the IDLE cycle.

## Test plan
- **ALU pass-through:** `mem_op = 00`, rd = 5, data = 0x1234, we = 1 → same-cycle `out_*` are 5 / 0x1234 / 1, forward valid, stall 0.
- **Signed byte load:** `BEAT_BYTES = 1`, LB at 0x100, done returns 0x80 → stall 2 cycles; FINISH gives `out_rd_data = 0xFFFFFF80`, `out_write_or_not = 1`. With `mem_unsigned` set, the result is 0x00000080.
- **Split word load:** `BEAT_BYTES = 1`, LW at 0x200 with beats returning 0x78, 0x56, 0x34, 0x12 → addresses 0x200 to 0x203 with `mc_len_o = 1`; result 0x12345678.
- **Half store on a 2-byte bus:** `BEAT_BYTES = 2`, SH of 0xABCD at 0x10 with grant delayed 3 cycles → `mc_req_o` and address held for 4 cycles; `mc_we_o = 1`, `mc_wdata_o = 0xABCD`, `mc_len_o = 2`; `out_write_or_not = 0`.
- **Load-use:** LW immediately followed by ADD → the ADD is not presented until the cycle after FINISH, and forwarding shows the loaded value during FINISH.
- **Reset mid-access:** assert `rst_in` low during WAIT of beat 2 → `mc_req_o`, stall and outputs are 0 at once; after release, a new SB completes normally.
